// File: rtl/l0l1_pkg.sv
// Shared L0/L1 path definitions: tag field widths, the {L0ID, BCID} tag layout
// and the default tag FIFO depth.
`ifndef RO_ADDR_WIDTH
`define RO_ADDR_WIDTH 8
`endif

package l0l1_pkg;

    localparam int L0ID_WIDTH = `RO_ADDR_WIDTH;
    localparam int BCID_WIDTH = 8;
    localparam int TAG_DEPTH  = 8;

    typedef struct packed {
        logic [L0ID_WIDTH-1:0] l0id;
        logic [BCID_WIDTH-1:0] bcid;
    } tag_t;

endpackage

// File: rtl/l0_tag_fifo.sv
// Generic synchronous FIFO with flush and occupancy. Pointers carry one extra
// wrap bit so that full and empty can be told apart.
module l0_tag_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign dout      = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & (~full | pop_ok) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/l0id_tag_writer.sv
// Write-side L0ID counter: numbers each L0 trigger, queues {L0ID, BCID} tags for
// readout and flags overflow, underflow and L0ID disagreement with the reader.
module l0id_tag_writer
    import l0l1_pkg::*;
#(
    parameter int L0ID_WIDTH = l0l1_pkg::L0ID_WIDTH,
    parameter int BCID_WIDTH = l0l1_pkg::BCID_WIDTH,
    parameter int DEPTH      = TAG_DEPTH
) (
    input  logic                      CLK,
    input  logic                      ResetB,
    input  logic                      L0,
    input  logic [BCID_WIDTH-1:0]     BCID,
    input  logic                      L0IDReset,
    input  logic                      L0IDPreset,
    input  logic [L0ID_WIDTH-1:0]     PreL0ID,
    input  logic                      ROReadStrob,
    input  logic [L0ID_WIDTH-1:0]     ExpectL0ID,
    input  logic                      ClearErr,
    output logic [L0ID_WIDTH-1:0]     L0ID,
    output logic [L0ID_WIDTH-1:0]     HeadL0ID,
    output logic [BCID_WIDTH-1:0]     HeadBCID,
    output logic                      TagValid,
    output logic [$clog2(DEPTH):0]    Occupancy,
    output logic                      Overflow,
    output logic                      Underflow,
    output logic                      L0IDMismatch
);

    localparam int TW = L0ID_WIDTH + BCID_WIDTH;

    logic [L0ID_WIDTH-1:0] l0id_q, l0id_d;
    logic [L0ID_WIDTH-1:0] l0id_inc;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  mismatch_q, mismatch_d;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop, fifo_flush;
    logic [TW-1:0]         head_tag;

    assign l0id_inc = l0id_q + L0ID_WIDTH'(1);

    always_comb begin
        l0id_d      = l0id_q;
        overflow_d  = overflow_q & ~ClearErr;
        underflow_d = underflow_q & ~ClearErr;
        mismatch_d  = mismatch_q & ~ClearErr;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        if (L0IDReset) begin
            l0id_d      = L0IDPreset ? PreL0ID : '1;
            fifo_flush  = 1'b1;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            mismatch_d  = 1'b0;
        end else begin
            fifo_pop  = ROReadStrob & ~fifo_empty;
            fifo_push = L0 & (~fifo_full | fifo_pop);
            // The counter advances even when the tag is dropped, keeping numbering in step.
            if (L0) l0id_d = l0id_inc;
            overflow_d  = overflow_d  | (L0 & ~fifo_push);
            underflow_d = underflow_d | (ROReadStrob & fifo_empty);
            mismatch_d  = mismatch_d  | (fifo_pop & (HeadL0ID != ExpectL0ID));
        end
    end

    always_ff @(posedge CLK or negedge ResetB) begin
        if (!ResetB) begin
            l0id_q      <= '1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            l0id_q      <= l0id_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mismatch_q  <= mismatch_d;
        end
    end

    l0_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (ResetB),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       ({l0id_inc, BCID}),
        .dout      (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (Occupancy)
    );

    assign L0ID         = l0id_q;
    assign HeadL0ID     = head_tag[TW-1:BCID_WIDTH];
    assign HeadBCID     = head_tag[BCID_WIDTH-1:0];
    assign TagValid     = ~fifo_empty;
    assign Overflow     = overflow_q;
    assign Underflow    = underflow_q;
    assign L0IDMismatch = mismatch_q;

endmodule

// File: tb/tb_l0id_tag_writer.sv
// Directed bench for l0id_tag_writer: expected tags are queued as triggers are
// issued and a monitor pops and compares them whenever the readout pops the head.
`timescale 1ns/1ps
module tb_l0id_tag_writer;

    logic       CLK = 1'b0;
    logic       ResetB;
    logic       L0;
    logic [7:0] BCID;
    logic       L0IDReset;
    logic       L0IDPreset;
    logic [7:0] PreL0ID;
    logic       ROReadStrob;
    logic [7:0] ExpectL0ID;
    logic       ClearErr;
    logic [7:0] L0ID;
    logic [7:0] HeadL0ID;
    logic [7:0] HeadBCID;
    logic       TagValid;
    logic [3:0] Occupancy;
    logic       Overflow;
    logic       Underflow;
    logic       L0IDMismatch;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb[$];

    always #5 CLK = ~CLK;

    l0id_tag_writer dut (
        .CLK          (CLK),
        .ResetB       (ResetB),
        .L0           (L0),
        .BCID         (BCID),
        .L0IDReset    (L0IDReset),
        .L0IDPreset   (L0IDPreset),
        .PreL0ID      (PreL0ID),
        .ROReadStrob  (ROReadStrob),
        .ExpectL0ID   (ExpectL0ID),
        .ClearErr     (ClearErr),
        .L0ID         (L0ID),
        .HeadL0ID     (HeadL0ID),
        .HeadBCID     (HeadBCID),
        .TagValid     (TagValid),
        .Occupancy    (Occupancy),
        .Overflow     (Overflow),
        .Underflow    (Underflow),
        .L0IDMismatch (L0IDMismatch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected tag at the head.
    always @(negedge CLK) begin
        if (ResetB && ROReadStrob && !L0IDReset && TagValid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got head 0x%0h/0x%0h, expected no tag",
                         HeadL0ID, HeadBCID);
            end else begin
                logic [15:0] exp_tag;
                exp_tag = sb.pop_front();
                $display("pop  l0id=0x%02h bcid=0x%02h expect=0x%02h",
                         HeadL0ID, HeadBCID, ExpectL0ID);
                check("pop_l0id", {24'd0, HeadL0ID}, {24'd0, exp_tag[15:8]});
                check("pop_bcid", {24'd0, HeadBCID}, {24'd0, exp_tag[7:0]});
            end
        end
    end

    task automatic step(input logic l0, input logic [7:0] bc, input logic rd,
                        input logic [7:0] exp, input logic clr);
        L0          = l0;
        BCID        = bc;
        ROReadStrob = rd;
        ExpectL0ID  = exp;
        ClearErr    = clr;
        @(posedge CLK);
        #1;
        L0          = 1'b0;
        ROReadStrob = 1'b0;
        ClearErr    = 1'b0;
    endtask

    task automatic trig(input logic [7:0] bc, input logic [7:0] exp_id);
        sb.push_back({exp_id, bc});
        step(1'b1, bc, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pop(input logic [7:0] exp_id);
        step(1'b0, 8'h00, 1'b1, exp_id, 1'b0);
    endtask

    task automatic l0id_reset(input logic preset, input logic [7:0] pre);
        L0IDReset  = 1'b1;
        L0IDPreset = preset;
        PreL0ID    = pre;
        @(posedge CLK);
        #1;
        L0IDReset  = 1'b0;
        L0IDPreset = 1'b0;
        sb.delete();
    endtask

    task automatic check_flags(input string tag, input logic ov, input logic un, input logic mm);
        check({tag, "_overflow"},  {31'd0, Overflow},     {31'd0, ov});
        check({tag, "_underflow"}, {31'd0, Underflow},    {31'd0, un});
        check({tag, "_mismatch"},  {31'd0, L0IDMismatch}, {31'd0, mm});
    endtask

    initial begin
        ResetB = 1'b0; L0 = 1'b0; BCID = 8'h00; L0IDReset = 1'b0; L0IDPreset = 1'b0;
        PreL0ID = 8'h00; ROReadStrob = 1'b0; ExpectL0ID = 8'h00; ClearErr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_l0id", {24'd0, L0ID}, 32'hFF);
        check("rst_occ", {28'd0, Occupancy}, 32'd0);
        check("rst_valid", {31'd0, TagValid}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        ResetB = 1'b1;
        @(posedge CLK);
        #1;

        // Three triggers, then three in-order pops
        trig(8'h10, 8'h00); trig(8'h11, 8'h01); trig(8'h12, 8'h02);
        check("t1_l0id", {24'd0, L0ID}, 32'h02);
        check("t1_occ", {28'd0, Occupancy}, 32'd3);
        check("t1_head_l0id", {24'd0, HeadL0ID}, 32'h00);
        check("t1_head_bcid", {24'd0, HeadBCID}, 32'h10);
        pop(8'h00); pop(8'h01); pop(8'h02);
        check("t1_occ_end", {28'd0, Occupancy}, 32'd0);
        check("t1_valid_end", {31'd0, TagValid}, 32'd0);
        check_flags("t1", 1'b0, 1'b0, 1'b0);

        // Preset near the top and wrap through 0xFF
        l0id_reset(1'b1, 8'hFD);
        check("t2_preset", {24'd0, L0ID}, 32'hFD);
        trig(8'h20, 8'hFE); trig(8'h21, 8'hFF); trig(8'h22, 8'h00); trig(8'h23, 8'h01);
        check("t2_l0id", {24'd0, L0ID}, 32'h01);
        check("t2_occ", {28'd0, Occupancy}, 32'd4);
        pop(8'hFE); pop(8'hFF); pop(8'h00); pop(8'h01);
        check_flags("t2", 1'b0, 1'b0, 1'b0);

        // Fill to DEPTH, ninth trigger is dropped
        l0id_reset(1'b0, 8'h00);
        check("t3_l0id_rst", {24'd0, L0ID}, 32'hFF);
        for (int i = 0; i < 8; i++) trig(8'h30 + 8'(i), 8'(i));
        step(1'b1, 8'h38, 1'b0, 8'h00, 1'b0);
        check("t3_occ_full", {28'd0, Occupancy}, 32'd8);
        check("t3_overflow", {31'd0, Overflow}, 32'd1);
        check("t3_l0id", {24'd0, L0ID}, 32'h08);
        check("t3_head", {24'd0, HeadL0ID}, 32'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("t3_clr_ovf", {31'd0, Overflow}, 32'd0);
        sb.push_back({8'h09, 8'h39});
        step(1'b1, 8'h39, 1'b1, 8'h00, 1'b0);
        check("t3_occ_pushpop", {28'd0, Occupancy}, 32'd8);
        check("t3_no_ovf", {31'd0, Overflow}, 32'd0);
        check("t3_l0id_09", {24'd0, L0ID}, 32'h09);
        for (int i = 1; i < 8; i++) pop(8'(i));
        pop(8'h09);
        check("t3_occ_end", {28'd0, Occupancy}, 32'd0);
        check_flags("t3", 1'b0, 1'b0, 1'b0);

        // Underflow: plain pop on empty, then trigger plus pop on empty
        pop(8'h00);
        check("t4_underflow", {31'd0, Underflow}, 32'd1);
        check("t4_occ0", {28'd0, Occupancy}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("t4_clr_unf", {31'd0, Underflow}, 32'd0);
        sb.push_back({8'h0A, 8'h40});
        step(1'b1, 8'h40, 1'b1, 8'h00, 1'b0);
        check("t4_occ1", {28'd0, Occupancy}, 32'd1);
        check("t4_underflow2", {31'd0, Underflow}, 32'd1);
        pop(8'h0A);
        check("t4_occ_end", {28'd0, Occupancy}, 32'd0);

        // Mismatch, clear, then flush with entries held
        l0id_reset(1'b0, 8'h00);
        check_flags("t5_rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) trig(8'h50 + 8'(i), 8'(i));
        pop(8'h01);
        check("t5_mismatch", {31'd0, L0IDMismatch}, 32'd1);
        check("t5_occ5", {28'd0, Occupancy}, 32'd5);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("t5_clr_mm", {31'd0, L0IDMismatch}, 32'd0);
        l0id_reset(1'b0, 8'h00);
        check("t5_occ_flush", {28'd0, Occupancy}, 32'd0);
        check("t5_valid_flush", {31'd0, TagValid}, 32'd0);
        check("t5_l0id_flush", {24'd0, L0ID}, 32'hFF);
        // Set beats clear when both land in the same cycle
        trig(8'h60, 8'h00);
        step(1'b0, 8'h00, 1'b1, 8'h05, 1'b1);
        check("t5_set_wins", {31'd0, L0IDMismatch}, 32'd1);

        // Asynchronous reset in the middle of traffic
        trig(8'h70, 8'h01); trig(8'h71, 8'h02); trig(8'h72, 8'h03); trig(8'h73, 8'h04);
        check("t6_occ4", {28'd0, Occupancy}, 32'd4);
        #2;
        ResetB = 1'b0;
        #1;
        sb.delete();
        check("t6_occ", {28'd0, Occupancy}, 32'd0);
        check("t6_valid", {31'd0, TagValid}, 32'd0);
        check("t6_l0id", {24'd0, L0ID}, 32'hFF);
        check_flags("t6", 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        ResetB = 1'b1;
        trig(8'h80, 8'h00);
        check("t6_after_l0id", {24'd0, L0ID}, 32'h00);
        pop(8'h00);
        check("sb_drained", sb.size(), 32'd0);

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
